// File: rtl/avr_intr_ctrl.sv
// Multi-source interrupt controller for avr_core: edge/level capture, masking, fixed priority, ack handshake.
// Optional AVR_INTR_SWTRIG_EN adds a write-only software-trigger register at IO_BASE+4.
module avr_intr_ctrl #(
   parameter int unsigned INTR_WIDTH = 2,
   parameter logic [5:0]  IO_BASE    = 6'h38
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [(2**INTR_WIDTH)-1:0]   irq_src,
   input  logic [5:0]                   io_a,
   input  logic                         io_re,
   input  logic                         io_we,
   input  logic [7:0]                   io_wd,
   output logic [7:0]                   io_rd,
   output logic                         iflag,
   output logic [INTR_WIDTH-1:0]        ivect,
   input  logic [(2**INTR_WIDTH)-1:0]   ieack
);

   localparam int unsigned N_SRC = 2**INTR_WIDTH;

   typedef enum logic {ST_IDLE, ST_REQ} state_t;

   state_t                 state, state_nx;
   logic [INTR_WIDTH-1:0]  vec_q, vec_nx, pick;
   logic                   found;
   logic [N_SRC-1:0]       sync1, sync2, sync_d;
   logic [N_SRC-1:0]       ifr, ifr_nx, imr, imod;
   logic [N_SRC-1:0]       elig, rise, w1c, swt, ack_clr;
   logic [5:0]             off;
   logic                   unused_wd;

   assign off       = io_a - IO_BASE;
   assign elig      = ifr & imr;
   assign rise      = sync2 & ~sync_d;
   assign w1c       = (io_we && off == 6'd0) ? io_wd[N_SRC-1:0] : '0;
   assign unused_wd = ^io_wd;

`ifdef AVR_INTR_SWTRIG_EN
   assign swt = (io_we && off == 6'd4) ? (io_wd[N_SRC-1:0] & imod) : '0;
`else
   assign swt = '0;
`endif

   always_comb begin
      pick  = '0;
      found = 1'b0;
      for (int unsigned i = 0; i < N_SRC; i++) begin
         if (elig[i] && !found) begin
            pick  = INTR_WIDTH'(i);
            found = 1'b1;
         end
      end
   end

   always_comb begin
      state_nx = state;
      vec_nx   = vec_q;
      ack_clr  = '0;
      case (state)
         ST_IDLE: begin
            if (found) begin
               state_nx = ST_REQ;
               vec_nx   = pick;
            end
         end
         ST_REQ: begin
            // Only the latched vector's ack counts; level channels keep their flag.
            if (ieack[vec_q]) begin
               state_nx       = ST_IDLE;
               ack_clr[vec_q] = imod[vec_q];
            end else if (!elig[vec_q]) begin
               state_nx = ST_IDLE;
            end
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   // Edge channels: hardware/software set overrides any clear in the same cycle.
   assign ifr_nx = (imod & ((ifr & ~(w1c | ack_clr)) | rise | swt)) | (~imod & sync2);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
         vec_q <= '0;
      end else begin
         state <= state_nx;
         vec_q <= vec_nx;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1  <= '0;
         sync2  <= '0;
         sync_d <= '0;
         ifr    <= '0;
         imr    <= '0;
         imod   <= '1;
      end else begin
         sync1  <= irq_src;
         sync2  <= sync1;
         sync_d <= sync2;
         ifr    <= ifr_nx;
         if (io_we && off == 6'd1) imr  <= io_wd[N_SRC-1:0];
         if (io_we && off == 6'd2) imod <= io_wd[N_SRC-1:0];
      end
   end

   always_comb begin
      io_rd = '0;
      if (io_re) begin
         case (off)
            6'd0: io_rd[N_SRC-1:0] = ifr;
            6'd1: io_rd[N_SRC-1:0] = imr;
            6'd2: io_rd[N_SRC-1:0] = imod;
            6'd3: begin
               io_rd[7]              = (state == ST_REQ);
               io_rd[INTR_WIDTH-1:0] = vec_q;
            end
            default: io_rd = '0;
         endcase
      end
   end

   assign iflag = (state == ST_REQ);
   assign ivect = vec_q;

endmodule
